pb_press_decoder: RTL and testbench

// - Consumes the debounced, active-low push-button level and classifies each gesture.

---
 rtl/pb_press_decoder.sv | 182 ++++++++++++++++++
 tb/tb_pb_press_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_press_decoder.sv
// pb_press_decoder
//   Classifies gestures on a debounced, active-low push-button level into
//   SHORT, LONG and DOUBLE presses (plus REPEAT while held when the
//   PB_AUTO_REPEAT_EN macro is defined). Each gesture yields one event code
//   through a single-entry valid/ready output register.
//
// Build option
//   PB_AUTO_REPEAT_EN : when defined, LONG_HELD emits REPEAT (2'b11) every
//                       REPEAT_CYCLES held cycles after the LONG event.
//
// Ports
//   clk          in   single clock
//   rst          in   synchronous, active-high reset
//   pb_in        in   debounced button level, 0 = pressed, synchronous to clk
//   evt_valid    out  event register holds an unconsumed event
//   evt_code     out  00 SHORT, 01 LONG, 10 DOUBLE, 11 REPEAT
//   evt_ready    in   consumer accepts; transfer on evt_valid & evt_ready
//   evt_dropped  out  one-cycle pulse: event generated while register full
//   pb_held      out  1 while in PRESSED, LONG_HELD or SECOND_PRESSED

module pb_press_decoder #(
    parameter int unsigned LONG_PRESS_CYCLES = 1000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 250,
    parameter int unsigned REPEAT_CYCLES     = 200,
    parameter int unsigned CNT_W = $clog2(
        ((LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES)
            > REPEAT_CYCLES
        ? ((LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES)
        : REPEAT_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_in,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_dropped,
    output logic       pb_held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_t;

    localparam logic [1:0] CODE_SHORT  = 2'b00;
    localparam logic [1:0] CODE_LONG   = 2'b01;
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
`ifdef PB_AUTO_REPEAT_EN
    localparam logic [1:0] CODE_REPEAT = 2'b11;
    // LONG_HELD counts held cycles starting from 1 so the first REPEAT
    // lands exactly REPEAT_CYCLES cycles after LONG.
    localparam logic [CNT_W-1:0] LONG_HELD_START = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] LONG_HELD_START = '0;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               gen;
    logic [1:0]         gen_code;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gen       = 1'b0;
        gen_code  = CODE_SHORT;
        case (state)
            IDLE: begin
                if (!pb_in) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESSED: begin
                if (pb_in) begin
                    state_nxt = WAIT_GAP;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
                    state_nxt = LONG_HELD;
                    cnt_nxt   = LONG_HELD_START;
                    gen       = 1'b1;
                    gen_code  = CODE_LONG;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LONG_HELD: begin
                if (pb_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
`ifdef PB_AUTO_REPEAT_EN
                else if (cnt == CNT_W'(REPEAT_CYCLES)) begin
                    cnt_nxt  = CNT_W'(1);
                    gen      = 1'b1;
                    gen_code = CODE_REPEAT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
`endif
            end
            WAIT_GAP: begin
                if (!pb_in) begin
                    state_nxt = SECOND_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DOUBLE_GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gen       = 1'b1;
                    gen_code  = CODE_SHORT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            SECOND_PRESSED: begin
                // Length of the second press is irrelevant: release is DOUBLE.
                if (pb_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gen       = 1'b1;
                    gen_code  = CODE_DOUBLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // pb_held is registered from the next state so it tracks the state
    // register without a cycle of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_held <= 1'b0;
        end else begin
            pb_held <= (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                       (state_nxt == SECOND_PRESSED);
        end
    end

    // Single-entry output register. A drain and a new event on the same
    // edge reload without a bubble; a new event into a full, non-draining
    // register is discarded and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid   <= 1'b0;
            evt_code    <= 2'b00;
            evt_dropped <= 1'b0;
        end else begin
            evt_dropped <= 1'b0;
            if (gen) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= gen_code;
                end else begin
                    evt_dropped <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_press_decoder.sv
// tb_pb_press_decoder
//   Directed bench for pb_press_decoder with LONG=20, GAP=10, REPEAT=5.
//   Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
//   a rising edge, so "edge k" below is the k-th rising edge after a change.

module tb_pb_press_decoder;

    localparam int unsigned LONG_C   = 20;
    localparam int unsigned GAP_C    = 10;
    localparam int unsigned REPEAT_C = 5;

    logic       clk;
    logic       rst;
    logic       pb_in;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_dropped;
    logic       pb_held;

    int checks = 0;
    int errors = 0;

    pb_press_decoder #(
        .LONG_PRESS_CYCLES (LONG_C),
        .DOUBLE_GAP_CYCLES (GAP_C),
        .REPEAT_CYCLES     (REPEAT_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pb_in       (pb_in),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_dropped (evt_dropped),
        .pb_held     (pb_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; pb_in = 1'b1; evt_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++;
        if (pb_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", pb_held); end
        checks++;
        if (evt_code !== 2'b00) begin errors++; $display("FAIL reset_code: got %b expected 00", evt_code); end
        checks++;
        if (evt_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", evt_dropped); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (evt_valid !== 1'b0 || evt_dropped !== 1'b0 || pb_held !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_short();
        int bad;
        pb_in = 1'b0;
        repeat (5) tick();
        checks++;
        if (pb_held !== 1'b1) begin errors++; $display("FAIL short_held: got %b expected 1", pb_held); end
        pb_in = 1'b1;
        bad = 0;
        for (int i = 1; i < int'(GAP_C); i++) begin
            tick();
            if (evt_valid !== 1'b0 || pb_held !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL short_early: got %0d bad cycles expected 0", bad); end
        tick();  // edge GAP after release
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b00)
            begin errors++; $display("FAIL short_event: got valid=%b code=%b expected valid=1 code=00", evt_valid, evt_code); end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL short_onecycle: got %b expected 0", evt_valid); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL short_single: got %0d extra event cycles expected 0", bad); end
    endtask

    task automatic test_long();
        int bad;
        pb_in = 1'b0;
        bad = 0;
        for (int i = 1; i < int'(LONG_C); i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL long_early: got %0d event cycles expected 0", bad); end
        tick();  // edge LONG
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01)
            begin errors++; $display("FAIL long_event: got valid=%b code=%b expected valid=1 code=01", evt_valid, evt_code); end
        checks++;
        if (pb_held !== 1'b1) begin errors++; $display("FAIL long_held: got %b expected 1", pb_held); end
        bad = 0;
        for (int k = int'(LONG_C) + 1; k <= 30; k++) begin
            tick();
`ifdef PB_AUTO_REPEAT_EN
            if (k == 25 || k == 30) begin
                if (evt_valid !== 1'b1 || evt_code !== 2'b11) bad++;
            end else if (evt_valid !== 1'b0) begin
                bad++;
            end
`else
            if (evt_valid !== 1'b0) bad++;
`endif
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL long_hold_events: got %0d wrong cycles expected 0", bad); end
        pb_in = 1'b1;
        tick();
        checks++;
        if (pb_held !== 1'b0) begin errors++; $display("FAIL long_release_held: got %b expected 0", pb_held); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL long_release_event: got %0d event cycles expected 0", bad); end
    endtask

    task automatic test_double();
        int bad;
        pb_in = 1'b0;
        repeat (5) tick();
        pb_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        pb_in = 1'b0;
        tick();
        checks++;
        if (pb_held !== 1'b1) begin errors++; $display("FAIL double_held: got %b expected 1", pb_held); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL double_early: got %0d event cycles expected 0", bad); end
        pb_in = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b10)
            begin errors++; $display("FAIL double_event: got valid=%b code=%b expected valid=1 code=10", evt_valid, evt_code); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL double_no_short: got %0d event cycles expected 0", bad); end
    endtask

    task automatic test_drop();
        int bad;
        evt_ready = 1'b0;
        pb_in = 1'b0;
        repeat (3) tick();
        pb_in = 1'b1;
        repeat (GAP_C) tick();
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b00)
            begin errors++; $display("FAIL drop_first_held: got valid=%b code=%b expected valid=1 code=00", evt_valid, evt_code); end
        pb_in = 1'b0;
        repeat (3) tick();
        pb_in = 1'b1;
        bad = 0;
        for (int i = 1; i < int'(GAP_C); i++) begin
            tick();
            if (evt_dropped !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL drop_early: got %0d pulses expected 0", bad); end
        tick();
        checks++;
        if (evt_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", evt_dropped); end
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b00)
            begin errors++; $display("FAIL drop_kept: got valid=%b code=%b expected valid=1 code=00", evt_valid, evt_code); end
        tick();
        checks++;
        if (evt_dropped !== 1'b0 || evt_valid !== 1'b1)
            begin errors++; $display("FAIL drop_one_cycle: got dropped=%b valid=%b expected dropped=0 valid=1", evt_dropped, evt_valid); end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL drop_drain: got %b expected 0", evt_valid); end
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        // Hold a SHORT, then raise ready on the same edge a DOUBLE is made.
        evt_ready = 1'b0;
        pb_in = 1'b0;
        repeat (3) tick();
        pb_in = 1'b1;
        repeat (GAP_C) tick();
        pb_in = 1'b0;
        repeat (3) tick();
        pb_in = 1'b1;
        repeat (2) tick();
        pb_in = 1'b0;
        repeat (3) tick();
        pb_in = 1'b1;
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_dropped !== 1'b0)
            begin errors++; $display("FAIL b2b_load: got valid=%b code=%b dropped=%b expected 1 10 0", evt_valid, evt_code, evt_dropped); end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", evt_valid); end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        pb_in = 1'b0;
        repeat (LONG_C + 2) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01 || pb_held !== 1'b1)
            begin errors++; $display("FAIL rstmid_pre: got valid=%b code=%b held=%b expected 1 01 1", evt_valid, evt_code, pb_held); end
        rst = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00 || pb_held !== 1'b0 || evt_dropped !== 1'b0)
            begin errors++; $display("FAIL rstmid_clear: got valid=%b code=%b held=%b dropped=%b expected 0 00 0 0", evt_valid, evt_code, pb_held, evt_dropped); end
        rst = 1'b0;
        tick();
        checks++;
        if (pb_held !== 1'b1 || evt_valid !== 1'b0)
            begin errors++; $display("FAIL rstmid_repress: got held=%b valid=%b expected held=1 valid=0", pb_held, evt_valid); end
        evt_ready = 1'b1;
        pb_in = 1'b1;
        repeat (GAP_C + 5) tick();
    endtask

    initial begin
        rst = 1'b1;
        pb_in = 1'b1;
        evt_ready = 1'b1;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
